real_capture_decimator: RTL and testbench
=========================================

Name: real_capture_decimator

Overview:
- Upstream of the real-value file-dump stage.
- Waits for a trigger, then samples a fixed-point real signal every DECIM cycles for NUM_SAMPLES samples.
- Buffers samples in a small FIFO and presents them with a valid/ready handshake, so the dump stage logs only a windowed, decimated record, not every clock.
- Synthesizable, so it can also run in emulation builds.

Parameters:
- WIDTH, 18, bit width of the signed fixed-point sample.
- EXPONENT, -12, real value = integer * 2^EXPONENT. Passed through to the consumer, no arithmetic applied.
- DECIM, 4, sample period in clk cycles. Legal range 1..65535.
- NUM_SAMPLES, 256, samples per capture window. Legal range 1..65535.
- FIFO_DEPTH, 8, output buffer entries. Must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous reset, active-high
- in_val  input  WIDTH  signed fixed-point sample source
- trig  input  1  start request, level-sampled in IDLE
- out_val  output  WIDTH  signed sample at FIFO head
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts out_val this cycle
- busy  output  1  high in CAPTURE or DRAIN
- done  output  1  one-cycle pulse at end of window
- overflow  output  1  sticky: at least one sample dropped in current or last window

Behaviour:
- Reset (async assert, sync release): state=IDLE, FIFO empty, all counters 0.
- Reset values: out_val=0, out_valid=0, busy=0, done=0, overflow=0.
- Reset mid-capture aborts the window, flushes the FIFO and produces no done pulse.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE, trig=1 at an edge:
  - Go to CAPTURE.
  - Clear decimation counter dc and sample counter sc.
  - Clear overflow.
  - The FIFO is not flushed; leftover entries stay valid.
- CAPTURE, each edge:
  - If dc==0, a sample is due: in_val at that edge is pushed and sc increments.
  - dc increments and wraps DECIM-1 -> 0. With DECIM=1, every cycle samples.
  - The first sample is taken on the first edge in CAPTURE, i.e. the edge after the one that saw trig.
- CAPTURE -> DRAIN on the edge that takes sample number NUM_SAMPLES. No further samples are taken.
- DRAIN -> DONE on the edge where the FIFO is empty, or becomes empty via a pop.
- DONE: done=1 for exactly one cycle, then IDLE.
- trig is ignored outside IDLE. A trig held high across DONE->IDLE starts a new window one cycle after IDLE.
- busy = (state==CAPTURE or state==DRAIN).
- FIFO:
  - Pop when out_valid and out_ready.
  - Push is accepted if occupancy<FIFO_DEPTH, or if a pop occurs in the same cycle (full + simultaneous pop/push keeps the FIFO full).
  - A due sample that is not accepted is dropped, still counts toward sc, and sets overflow (sticky until the next accepted trig).
  - out_val/out_valid are registered from head/occupancy. Latency: a sample pushed into an empty FIFO at edge k appears with out_valid=1 after edge k.
  - out_val holds the last head value while out_valid=0; consumers must not use it then.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- Counters: dc is 16 bits, sc is 16 bits.
- No arithmetic on samples. Bit pattern passes through unchanged, sign included.

Test Plan:
- Basic window: DECIM=4, NUM_SAMPLES=3, out_ready=1, in_val = cycle index after trig (0,1,2,...); trig at edge 0 → out sequence 1,5,9 (each valid one cycle after capture), done pulse once after last pop, busy low after done.
- Backpressure/overflow: DECIM=1, FIFO_DEPTH=4, NUM_SAMPLES=6, out_ready=0 throughout window, then 1 → first 4 samples delivered in order, last 2 dropped, overflow=1; next trig clears overflow.
- Full with simultaneous pop: DECIM=1, FIFO_DEPTH=4, out_ready toggling 1/0 → no drop while a pop coincides with the push at full, overflow stays 0, order preserved.
- Signed passthrough: WIDTH=18, in_val=-1 (all ones) then -131072 (0x20000) → out_val bit-identical.
- Reset mid-capture: assert rst for 1 ns mid-window with 2 entries buffered → all outputs 0 immediately (before next clk), no done pulse, next trig starts a clean window.
- Ignored trig + retrigger: pulse trig during CAPTURE → sample count unchanged (exactly NUM_SAMPLES outputs); hold trig high through DONE → second window starts one cycle after IDLE.

Source files
------------

// File: rtl/real_capture_decimator_if.sv
// ---------------------------------------------------------------------------
// real_capture_decimator_if
// Output stream of the capture decimator toward the real-value dump stage.
//   val      : two's-complement fixed-point sample at FIFO head (bit pattern)
//   valid    : FIFO non-empty, val is meaningful
//   ready    : consumer accepts val this cycle
//   exponent : real value = val * 2^exponent, constant for a given build
// master = decimator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface real_capture_decimator_if #(
    parameter int WIDTH = 18
);
    logic [WIDTH-1:0]  val;
    logic              valid;
    logic              ready;
    logic signed [7:0] exponent;

    modport master (output val, output valid, output exponent, input ready);
    modport slave  (input val, input valid, input exponent, output ready);
endinterface

// File: rtl/real_capture_decimator.sv
// ---------------------------------------------------------------------------
// real_capture_decimator
// Waits for a trigger, then samples i_in_val every DECIM cycles for
// NUM_SAMPLES samples into a small FIFO drained over a valid/ready stream.
//
// Ports:
//   clk        : system clock, all state on rising edge
//   rst        : asynchronous reset, active-high
//   i_in_val   : fixed-point sample source (two's complement, WIDTH bits)
//   i_trig     : start request, level-sampled in IDLE only
//   o_busy     : high in CAPTURE or DRAIN
//   o_done     : one-cycle pulse at end of window
//   o_overflow : sticky, a due sample was dropped since the last accepted trig
//   m_out      : output stream (val/valid/ready/exponent)
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for i_trig; leftover FIFO entries still drain
// CAPTURE | sampling every DECIM cycles until NUM_SAMPLES are due
// DRAIN   | no sampling, waiting for the FIFO to empty
// DONE    | o_done pulse, back to IDLE next edge
// ---------------------------------------------------------------------------
module real_capture_decimator #(
    parameter int WIDTH       = 18,
    parameter int EXPONENT    = -12,
    parameter int DECIM       = 4,
    parameter int NUM_SAMPLES = 256,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WIDTH-1:0]                  i_in_val,
    input  logic                              i_trig,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_overflow,
    real_capture_decimator_if.master          m_out
);

    localparam int           AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]  DC_LAST  = 16'(DECIM - 1);
    localparam logic [15:0]  SC_LAST  = 16'(NUM_SAMPLES - 1);

    if (DECIM < 1 || DECIM > 65535) begin : g_bad_decim
        $error("DECIM must be in 1..65535");
    end
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 65535) begin : g_bad_num
        $error("NUM_SAMPLES must be in 1..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_dc;
    logic [15:0]      r_sc;
    logic             r_overflow;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_after_pop;
    logic [AW:0]      w_count_next;
    logic [WIDTH-1:0] r_out_val;
    logic [WIDTH-1:0] w_head_next;
    logic             r_out_valid;

    logic             w_due;
    logic             w_last;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_due  = (r_state == S_CAPTURE) && (r_dc == 16'd0);
    assign w_last = w_due && (r_sc == SC_LAST);
    assign w_pop  = r_out_valid && m_out.ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = w_due && ((r_count != FULL_CNT) || w_pop);
    assign w_drop = w_due && !w_push;

    assign w_count_after_pop = r_count - (AW+1)'(w_pop);
    assign w_count_next      = w_count_after_pop + (AW+1)'(w_push);
    assign w_rd_ptr_next     = r_rd_ptr + AW'(w_pop);

    // Next registered head. When the FIFO is (or becomes) empty before the
    // push, the new head is the sample being written this edge and is not in
    // memory yet, so bypass it from the input.
    always_comb begin
        w_head_next = r_out_val;
        if (w_count_next != '0) begin
            if (w_count_after_pop == '0) begin
                w_head_next = i_in_val;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_trig) begin
                    w_state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_count_after_pop == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dc        <= '0;
            r_sc        <= '0;
            r_overflow  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_val   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wr_ptr    <= r_wr_ptr + AW'(w_push);
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != '0);
            r_out_val   <= w_head_next;

            if (r_state == S_IDLE && i_trig) begin
                r_dc       <= '0;
                r_sc       <= '0;
                r_overflow <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                if (w_due) begin
                    r_sc <= r_sc + 16'd1;
                end
                r_dc <= (r_dc == DC_LAST) ? 16'd0 : r_dc + 16'd1;
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_val;
        end
    end

    assign o_busy         = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
    assign o_done         = (r_state == S_DONE);
    assign o_overflow     = r_overflow;
    assign m_out.val      = r_out_val;
    assign m_out.valid    = r_out_valid;
    assign m_out.exponent = 8'(EXPONENT);

endmodule

// File: tb/tb_real_capture_decimator.sv
// ---------------------------------------------------------------------------
// tb_real_capture_decimator
// Two instances: u_a (DECIM=4, NUM_SAMPLES=3, FIFO_DEPTH=8) for the basic
// window, ignored trig and held-trig retrigger; u_b (DECIM=1, NUM_SAMPLES=6,
// FIFO_DEPTH=4) for backpressure, full+pop, signed passthrough and reset.
// Expected values are hand-derived edge by edge.
// ---------------------------------------------------------------------------
module tb_real_capture_decimator;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         trig_a;
    logic         trig_b;
    logic         busy_a, done_a, ovf_a;
    logic         busy_b, done_b, ovf_b;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    // Window B2 stimulus: ready per edge and expected head after each edge.
    bit b2_rdy  [12] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    int b2_head [10] = '{0, 201, 201, 201, 202, 202, 203, 204, 205, 206};

    always #5 clk = ~clk;

    real_capture_decimator_if #(.WIDTH(W)) if_a ();
    real_capture_decimator_if #(.WIDTH(W)) if_b ();

    real_capture_decimator #(
        .WIDTH(W), .EXPONENT(-12), .DECIM(4), .NUM_SAMPLES(3), .FIFO_DEPTH(8)
    ) u_a (
        .clk(clk), .rst(rst), .i_in_val(in_a), .i_trig(trig_a),
        .o_busy(busy_a), .o_done(done_a), .o_overflow(ovf_a), .m_out(if_a)
    );

    real_capture_decimator #(
        .WIDTH(W), .EXPONENT(-12), .DECIM(1), .NUM_SAMPLES(6), .FIFO_DEPTH(4)
    ) u_b (
        .clk(clk), .rst(rst), .i_in_val(in_b), .i_trig(trig_b),
        .o_busy(busy_b), .o_done(done_b), .o_overflow(ovf_b), .m_out(if_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_a      = '0;
        in_b      = '0;
        trig_a    = 1'b0;
        trig_b    = 1'b0;
        if_a.ready = 1'b1;
        if_b.ready = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("rst_a_valid", if_a.valid, 0);
        chk("rst_a_val",   if_a.val,   0);
        chk("rst_a_busy",  busy_a,     0);
        chk("rst_a_done",  done_a,     0);
        chk("rst_a_ovf",   ovf_a,      0);
        chk("rst_b_valid", if_b.valid, 0);
        chk("rst_b_val",   if_b.val,   0);
        chk("rst_b_busy",  busy_b,     0);
        chk("rst_b_done",  done_b,     0);
        chk("rst_b_ovf",   ovf_b,      0);
        chk("exponent",    32'(if_a.exponent), 32'hFFFF_FFF4);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ---------------- A: basic window with an ignored trig pulse ----------------
        trig_a = 1'b1;
        in_a   = '0;
        tick();
        chk("a1_busy_start", busy_a, 1);
        trig_a = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            bit ev;
            in_a   = W'(j);
            trig_a = (j == 4);
            tick();
            ev = (j == 1 || j == 5 || j == 9);
            chk("a1_valid", if_a.valid, ev);
            if (ev) chk("a1_val", if_a.val, j);
            chk("a1_done", done_a, (j == 10));
            chk("a1_busy", busy_a, (j <= 9));
            if (done_a) n_done++;
        end
        trig_a = 1'b0;
        chk("a1_done_count", n_done, 1);

        // ---------------- A: trig held high through DONE -> back-to-back windows ----------------
        trig_a = 1'b1;
        in_a   = '0;
        tick();
        for (int k = 1; k <= 24; k++) begin
            bit ev;
            in_a   = W'(k);
            trig_a = (k <= 12);
            tick();
            ev = (k == 1 || k == 5 || k == 9 || k == 13 || k == 17 || k == 21);
            chk("a2_valid", if_a.valid, ev);
            if (ev) chk("a2_val", if_a.val, k);
            chk("a2_done", done_a, (k == 10 || k == 22));
            chk("a2_busy", busy_a, (k <= 9) || (k >= 12 && k <= 21));
        end

        // ---------------- B: backpressure and overflow ----------------
        if_b.ready = 1'b0;
        trig_b     = 1'b1;
        in_b       = '0;
        tick();
        trig_b = 1'b0;
        chk("b1_ovf_start", ovf_b, 0);
        for (int k = 1; k <= 11; k++) begin
            in_b       = W'(100 + k);
            if_b.ready = (k >= 7);
            tick();
            chk("b1_ovf",   ovf_b,      (k >= 5));
            chk("b1_valid", if_b.valid, (k <= 9));
            if (k <= 9) chk("b1_val", if_b.val, (k <= 6) ? 101 : 95 + k);
            chk("b1_done",  done_b,     (k == 10));
            chk("b1_busy",  busy_b,     (k <= 9));
        end
        chk("b1_ovf_sticky", ovf_b, 1);

        // ---------------- B: full FIFO with simultaneous pop/push ----------------
        if_b.ready = 1'b0;
        trig_b     = 1'b1;
        in_b       = W'(200);
        tick();
        trig_b = 1'b0;
        chk("b2_ovf_cleared", ovf_b, 0);
        for (int k = 1; k <= 11; k++) begin
            in_b       = W'(200 + k);
            if_b.ready = b2_rdy[k];
            tick();
            chk("b2_valid", if_b.valid, (k <= 9));
            if (k <= 9) chk("b2_val", if_b.val, b2_head[k]);
            chk("b2_done", done_b, (k == 10));
            chk("b2_ovf",  ovf_b,  0);
        end

        // ---------------- B: signed passthrough ----------------
        if_b.ready = 1'b1;
        trig_b     = 1'b1;
        in_b       = '0;
        tick();
        trig_b = 1'b0;
        in_b   = 18'h3FFFF;
        tick();
        chk("b3_valid_neg1", if_b.valid, 1);
        chk("b3_val_neg1",   if_b.val,   32'h3FFFF);
        in_b = 18'h20000;
        tick();
        chk("b3_val_min",    if_b.val,   32'h20000);
        in_b = '0;
        for (int n = 0; n < 30 && done_b !== 1'b1; n++) tick();
        chk("b3_done_seen", done_b, 1);
        tick();

        // ---------------- B: reset mid-capture ----------------
        if_b.ready = 1'b0;
        trig_b     = 1'b1;
        in_b       = '0;
        tick();
        trig_b = 1'b0;
        in_b   = W'(7);
        tick();
        in_b = W'(8);
        tick();
        chk("b4_pre_valid", if_b.valid, 1);
        chk("b4_pre_val",   if_b.val,   7);
        chk("b4_pre_busy",  busy_b,     1);
        #2;
        rst = 1'b1;
        #1;
        chk("b4_rst_valid", if_b.valid, 0);
        chk("b4_rst_val",   if_b.val,   0);
        chk("b4_rst_busy",  busy_b,     0);
        chk("b4_rst_done",  done_b,     0);
        chk("b4_rst_ovf",   ovf_b,      0);
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("b4_post_done",  done_b,     0);
            chk("b4_post_busy",  busy_b,     0);
            chk("b4_post_valid", if_b.valid, 0);
        end

        // clean window after reset: streaming with ready held high
        if_b.ready = 1'b1;
        trig_b     = 1'b1;
        in_b       = '0;
        tick();
        trig_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            in_b = W'(300 + k);
            tick();
            chk("b5_valid", if_b.valid, (k <= 6));
            if (k <= 6) chk("b5_val", if_b.val, 300 + k);
            chk("b5_done", done_b, (k == 7));
        end
        chk("b5_ovf", ovf_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
